// File: rtl/afifo_read_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : afifo_read_checker_if
// Description : First-word-fall-through read port of the async FIFO.
//               master = consumer (drives r), slave = FIFO (drives rd/rempty).
// Revision    : 1.0  initial release
// ============================================================================
interface afifo_read_checker_if #(
    parameter int WIDTH = 12
);
    logic             r;
    logic [WIDTH-1:0] rd;
    logic             rempty;

    modport master (output r, input rd, input rempty);
    modport slave  (input r, output rd, output rempty);
endinterface
`default_nettype wire

// File: rtl/afifo_read_checker.sv
`default_nettype none
// ============================================================================
// Module      : afifo_read_checker
// Description : Read-side soak-test consumer for the async FIFO. Pops words,
//               checks they increment by one modulo 2^WIDTH, counts pops and
//               latches the first mismatch. Optional idle gap between pops.
// Revision    : 1.0  initial release
// ============================================================================
module afifo_read_checker #(
    parameter int WIDTH       = 12,
    parameter int PACE_WIDTH  = 4,
    parameter int COUNT_WIDTH = 16,
    parameter bit CHECK_FIRST = 1'b0
) (
    input  wire logic                   rclk,
    input  wire logic                   rrst_,
    afifo_read_checker_if.master        fifo,
    input  wire logic                   en,
    input  wire logic [PACE_WIDTH-1:0]  pace,
    output logic                        ok,
    output logic [COUNT_WIDTH-1:0]      rcount,
    output logic [WIDTH-1:0]            errExpected,
    output logic [WIDTH-1:0]            errGot
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_WAIT = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [PACE_WIDTH-1:0]   pace_ctr_q, pace_ctr_d;
    logic [WIDTH-1:0]        expected_q, expected_d;
    logic                    seeded_q, seeded_d;
    logic                    ok_q, ok_d;
    logic [COUNT_WIDTH-1:0]  rcount_q, rcount_d;
    logic [WIDTH-1:0]        err_expected_q, err_expected_d;
    logic [WIDTH-1:0]        err_got_q, err_got_d;

    logic                    w_read;
    logic                    w_pop;

    // Read request follows en combinationally so dropping en never pops
    assign w_read = (state_q == S_READ) && en;
    assign w_pop  = w_read && !fifo.rempty;
    assign fifo.r = w_read;

    assign ok          = ok_q;
    assign rcount      = rcount_q;
    assign errExpected = err_expected_q;
    assign errGot      = err_got_q;

    // Next-state, sequence check and pop counting
    always_comb begin
        state_d        = state_q;
        pace_ctr_d     = pace_ctr_q;
        expected_d     = expected_q;
        seeded_d       = seeded_q;
        ok_d           = ok_q;
        rcount_d       = rcount_q;
        err_expected_d = err_expected_q;
        err_got_d      = err_got_q;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (w_pop) begin
                    // The pop counts even when it is the erroring one
                    if (!(&rcount_q)) begin
                        rcount_d = rcount_q + 1'b1;
                    end
                    if (seeded_q && (fifo.rd != expected_q)) begin
                        ok_d           = 1'b0;
                        err_expected_d = expected_q;
                        err_got_d      = fifo.rd;
                        state_d        = S_ERR;
                    end else begin
                        // An unseeded pop just establishes the sequence origin
                        expected_d = fifo.rd + 1'b1;
                        seeded_d   = 1'b1;
                        if (pace != '0) begin
                            pace_ctr_d = pace;
                            state_d    = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (!en) begin
                    pace_ctr_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    pace_ctr_d = pace_ctr_q - 1'b1;
                    if (pace_ctr_q == PACE_WIDTH'(1)) begin
                        state_d = S_READ;
                    end
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers, asynchronous active-low reset
    always_ff @(posedge rclk or negedge rrst_) begin
        if (!rrst_) begin
            state_q        <= S_IDLE;
            pace_ctr_q     <= '0;
            expected_q     <= '0;
            seeded_q       <= CHECK_FIRST;
            ok_q           <= 1'b1;
            rcount_q       <= '0;
            err_expected_q <= '0;
            err_got_q      <= '0;
        end else begin
            state_q        <= state_d;
            pace_ctr_q     <= pace_ctr_d;
            expected_q     <= expected_d;
            seeded_q       <= seeded_d;
            ok_q           <= ok_d;
            rcount_q       <= rcount_d;
            err_expected_q <= err_expected_d;
            err_got_q      <= err_got_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_afifo_read_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_afifo_read_checker
// Description : Scoreboard bench for afifo_read_checker. A FIFO model feeds
//               dut0 (unseeded start); dut1 starts with a required first word
//               of zero. Expected per-pop results are queued by the stimulus
//               and consumed by per-DUT monitors.
// Revision    : 1.0  initial release
// ============================================================================
module tb_afifo_read_checker;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic [11:0] word;
        logic        ok;
        logic [15:0] cnt;
        logic [11:0] ee;
        logic [11:0] eg;
    } exp_t;

    logic        rclk = 1'b0;
    logic        rrst_n = 1'b0;
    logic        en0 = 1'b0;
    logic        en1 = 1'b0;
    logic [3:0]  pace0 = 4'd0;
    logic        ok0, ok1;
    logic [15:0] rcount0, rcount1;
    logic [11:0] ee0, eg0, ee1, eg1;

    logic        m_empty = 1'b1;
    logic [11:0] m_rd = 12'd0;
    logic        m1_empty = 1'b1;
    logic [11:0] m1_rd = 12'd0;

    logic [11:0] fifo_q[$];
    logic [11:0] pend_q[$];
    exp_t        exp0_q[$];
    exp_t        exp1_q[$];

    int          checks = 0;
    int          errors = 0;
    logic        saw_full = 1'b0;
    logic        gap_chk = 1'b0;
    int          gap_exp = 0;
    int          r0_cnt = 0;
    logic        have_prev = 1'b0;

    afifo_read_checker_if #(.WIDTH(12)) bus0 ();
    afifo_read_checker_if #(.WIDTH(12)) bus1 ();

    assign bus0.rd     = m_rd;
    assign bus0.rempty = m_empty;
    assign bus1.rd     = m1_rd;
    assign bus1.rempty = m1_empty;

    afifo_read_checker #(.WIDTH(12), .PACE_WIDTH(4), .COUNT_WIDTH(16), .CHECK_FIRST(1'b0)) dut0 (
        .rclk(rclk), .rrst_(rrst_n), .fifo(bus0), .en(en0), .pace(pace0),
        .ok(ok0), .rcount(rcount0), .errExpected(ee0), .errGot(eg0)
    );

    afifo_read_checker #(.WIDTH(12), .PACE_WIDTH(4), .COUNT_WIDTH(16), .CHECK_FIRST(1'b1)) dut1 (
        .rclk(rclk), .rrst_(rrst_n), .fifo(bus1), .en(en1), .pace(4'd0),
        .ok(ok1), .rcount(rcount1), .errExpected(ee1), .errGot(eg1)
    );

    always #3 rclk = ~rclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_cmp(input string tag, input exp_t e, input logic [11:0] w, input logic o,
                           input logic [15:0] c, input logic [11:0] ee, input logic [11:0] eg);
        checks++;
        if (e.word !== w || e.ok !== o || e.cnt !== c || e.ee !== ee || e.eg !== eg) begin
            errors++;
            $display("FAIL %s pop: got word=%0h ok=%0b cnt=%0d ee=%0h eg=%0h expected word=%0h ok=%0b cnt=%0d ee=%0h eg=%0h",
                     tag, w, o, c, ee, eg, e.word, e.ok, e.cnt, e.ee, e.eg);
        end
    endtask

    // FIFO model: pop on r & !rempty, admit one pending producer word per cycle
    always @(posedge rclk) begin
        if (bus0.r && !bus0.rempty && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
        end
        if (pend_q.size() > 0 && fifo_q.size() < DEPTH) begin
            fifo_q.push_back(pend_q.pop_front());
        end
        if (fifo_q.size() == DEPTH) begin
            saw_full = 1'b1;
        end
        m_empty <= (fifo_q.size() == 0);
        m_rd    <= (fifo_q.size() > 0) ? fifo_q[0] : 12'd0;
    end

    // Monitor for dut0: gap of r=0 cycles between pops, then per-pop results
    always @(posedge rclk) begin
        logic [11:0] popped;
        if (!rrst_n) begin
            have_prev = 1'b0;
            r0_cnt    = 0;
        end else if (bus0.r && !bus0.rempty) begin
            popped = bus0.rd;
            if (gap_chk && have_prev) begin
                checks++;
                if (r0_cnt != gap_exp) begin
                    errors++;
                    $display("FAIL gap: got %0d idle cycles expected %0d", r0_cnt, gap_exp);
                end
            end
            have_prev = 1'b1;
            r0_cnt    = 0;
            #1;
            if (exp0_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0 unexpected pop: got word=%0h expected no pop", popped);
            end else begin
                mon_cmp("dut0", exp0_q.pop_front(), popped, ok0, rcount0, ee0, eg0);
            end
        end else if (!bus0.r) begin
            r0_cnt++;
        end
    end

    // Monitor for dut1
    always @(posedge rclk) begin
        logic [11:0] popped1;
        if (rrst_n && bus1.r && !bus1.rempty) begin
            popped1 = bus1.rd;
            #1;
            if (exp1_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1 unexpected pop: got word=%0h expected no pop", popped1);
            end else begin
                mon_cmp("dut1", exp1_q.pop_front(), popped1, ok1, rcount1, ee1, eg1);
            end
        end
    end

    task automatic push(input logic [11:0] w, input logic o, input logic [15:0] c,
                        input logic [11:0] ee, input logic [11:0] eg);
        pend_q.push_back(w);
        exp0_q.push_back('{word: w, ok: o, cnt: c, ee: ee, eg: eg});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp0_q.size() != 0 && n < budget) begin
            @(negedge rclk);
            n++;
        end
        check({name, "_drain"}, 32'(exp0_q.size()), 32'd0);
        exp0_q.delete();
    endtask

    task automatic do_reset();
        @(negedge rclk);
        #1 rrst_n = 1'b0;
        #1;
        check("rst_r", 32'(bus0.r), 32'd0);
        check("rst_ok_cnt", {15'd0, ok0, rcount0}, {15'd0, 1'b1, 16'd0});
        check("rst_err", {8'd0, ee0, eg0}, 32'd0);
        repeat (2) @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    initial begin
        logic any_r;
        int   n;

        // Reset state
        repeat (2) @(negedge rclk);
        check("init_r", 32'(bus0.r), 32'd0);
        check("init_ok_cnt", {15'd0, ok0, rcount0}, {15'd0, 1'b1, 16'd0});
        check("init_err", {8'd0, ee0, eg0}, 32'd0);
        rrst_n = 1'b1;

        // First word must be zero on dut1: 7 is an error at the first pop
        en1 = 1'b1;
        repeat (2) @(negedge rclk);
        exp1_q.push_back('{word: 12'd7, ok: 1'b0, cnt: 16'd1, ee: 12'd0, eg: 12'd7});
        m1_rd = 12'd7;
        m1_empty = 1'b0;
        @(negedge rclk);
        m1_rd = 12'd8;
        any_r = 1'b0;
        repeat (6) begin
            @(negedge rclk);
            any_r = any_r | bus1.r;
        end
        m1_empty = 1'b1;
        check("chkfirst_r_stuck", 32'(any_r), 32'd0);
        check("chkfirst_drain", 32'(exp1_q.size()), 32'd0);

        // Seeded stream 5..8, back-to-back
        en0 = 1'b1;
        gap_chk = 1'b1;
        gap_exp = 0;
        push(12'd5, 1'b1, 16'd1, 12'd0, 12'd0);
        push(12'd6, 1'b1, 16'd2, 12'd0, 12'd0);
        push(12'd7, 1'b1, 16'd3, 12'd0, 12'd0);
        push(12'd8, 1'b1, 16'd4, 12'd0, 12'd0);
        wait_drain("seeded", 100);
        check("seeded_cnt", 32'(rcount0), 32'd4);

        // Wrap through 0xFFF -> 0x000
        do_reset();
        push(12'hFFE, 1'b1, 16'd1, 12'd0, 12'd0);
        push(12'hFFF, 1'b1, 16'd2, 12'd0, 12'd0);
        push(12'h000, 1'b1, 16'd3, 12'd0, 12'd0);
        push(12'h001, 1'b1, 16'd4, 12'd0, 12'd0);
        wait_drain("wrap", 100);
        check("wrap_ok_cnt", {15'd0, ok0, rcount0}, {15'd0, 1'b1, 16'd4});

        // Mismatch: 0,1,2,4 -> error on 4, word 5 must stay in the FIFO
        do_reset();
        push(12'd0, 1'b1, 16'd1, 12'd0, 12'd0);
        push(12'd1, 1'b1, 16'd2, 12'd0, 12'd0);
        push(12'd2, 1'b1, 16'd3, 12'd0, 12'd0);
        push(12'd4, 1'b0, 16'd4, 12'd3, 12'd4);
        pend_q.push_back(12'd5);
        wait_drain("mismatch", 100);
        any_r = 1'b0;
        repeat (10) begin
            @(negedge rclk);
            any_r = any_r | bus0.r;
        end
        check("mismatch_r_stuck", 32'(any_r), 32'd0);
        check("mismatch_err", {8'd0, ee0, eg0}, {8'd0, 12'd3, 12'd4});
        check("mismatch_ok_cnt", {15'd0, ok0, rcount0}, {15'd0, 1'b0, 16'd4});
        check("mismatch_left", {20'd0, (fifo_q.size() > 0) ? fifo_q[0] : 12'hABC}, 32'd5);
        check("mismatch_left_n", 32'(fifo_q.size()), 32'd1);

        // Pacing: leftover 5 reseeds; slow then fast producer, 15 idle cycles
        gap_chk = 1'b1;
        gap_exp = 15;
        pace0 = 4'd15;
        do_reset();
        exp0_q.push_back('{word: 12'd5, ok: 1'b1, cnt: 16'd1, ee: 12'd0, eg: 12'd0});
        for (int w = 6; w <= 8; w++) begin
            #84;
            push(12'(w), 1'b1, 16'(w - 4), 12'd0, 12'd0);
        end
        saw_full = 1'b0;
        for (int w = 9; w <= 20; w++) begin
            push(12'(w), 1'b1, 16'(w - 4), 12'd0, 12'd0);
        end
        wait_drain("pace", 1000);
        check("pace_full", 32'(saw_full), 32'd1);
        check("pace_ok_cnt", {15'd0, ok0, rcount0}, {15'd0, 1'b1, 16'd16});
        gap_chk = 1'b0;
        pace0 = 4'd0;
        for (int w = 21; w <= 24; w++) begin
            push(12'(w), 1'b1, 16'(w - 4), 12'd0, 12'd0);
        end
        wait_drain("resume", 200);
        check("resume_ok_cnt", {15'd0, ok0, rcount0}, {15'd0, 1'b1, 16'd20});

        // Pause: toggle en every 3 cycles while streaming
        do_reset();
        for (int w = 25; w <= 36; w++) begin
            push(12'(w), 1'b1, 16'(w - 24), 12'd0, 12'd0);
        end
        for (int i = 0; i < 200 && exp0_q.size() != 0; i++) begin
            repeat (3) @(negedge rclk);
            en0 = ~en0;
        end
        en0 = 1'b1;
        wait_drain("pause", 100);
        check("pause_ok_cnt", {15'd0, ok0, rcount0}, {15'd0, 1'b1, 16'd12});

        // Reset mid-READ: r drops at once, remaining words restart the count
        for (int w = 37; w <= 48; w++) begin
            push(12'(w), 1'b1, 16'(w - 24), 12'd0, 12'd0);
        end
        for (int i = 0; i < 200 && exp0_q.size() > 8; i++) begin
            @(negedge rclk);
        end
        #1 rrst_n = 1'b0;
        #1;
        check("midrst_r", 32'(bus0.r), 32'd0);
        check("midrst_ok_cnt", {15'd0, ok0, rcount0}, {15'd0, 1'b1, 16'd0});
        exp0_q.delete();
        n = 0;
        foreach (fifo_q[i]) begin
            n++;
            exp0_q.push_back('{word: fifo_q[i], ok: 1'b1, cnt: 16'(n), ee: 12'd0, eg: 12'd0});
        end
        foreach (pend_q[i]) begin
            n++;
            exp0_q.push_back('{word: pend_q[i], ok: 1'b1, cnt: 16'(n), ee: 12'd0, eg: 12'd0});
        end
        @(negedge rclk);
        rrst_n = 1'b1;
        wait_drain("midrst", 200);
        check("midrst_final", {15'd0, ok0, rcount0}, {15'd0, 1'b1, 16'(n)});

        repeat (2) @(negedge rclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/afifo_read_checker.md
Name: afifo_read_checker

Overview:
- Read-side consumer for the async FIFO, in the rclk domain.
- Drains the FIFO through its first-word-fall-through read port (r/rd/rempty).
- Checks that popped words form a strictly incrementing sequence modulo 2^Width, counts pops, and latches the first mismatch.
- Counterpart to the incrementing-value write-side producer.
- Used on hardware and in simulation to soak-test clock-domain crossing; an optional pacing gap lets the bench drive the FIFO to full.

Parameters:
- Width, 12, data word width; must match the FIFO's Width.
- PaceWidth, 4, width of the pace input (idle cycles inserted between pops).
- CountWidth, 16, width of the pop counter.
- CheckFirst, 0, 1 = first popped word must equal 0; 0 = first word is accepted as the sequence seed.

Ports:
- rclk  in  1  read-domain clock; all state updates on posedge.
- rrst_  in  1  reset, asynchronous assert, active-low.
- en  in  1  consume enable; sampled every cycle.
- pace  in  PaceWidth  idle cycles between pops; sampled at the pop edge.
- r  out  1  FIFO read request; combinational: (state==READ) & en.
- rd  in  Width  FIFO head word, valid whenever rempty==0.
- rempty  in  1  FIFO empty flag.
- ok  out  1  1 until the first sequence error; sticky 0 afterwards.
- rcount  out  CountWidth  number of pops, saturating at all-ones.
- errExpected  out  Width  expected value at the first error.
- errGot  out  Width  value actually read at the first error.

Behaviour:
- Reset (rrst_=0, async): state=IDLE, r=0, ok=1, rcount=0, errExpected=0, errGot=0.
  - Internal on reset: expected=0; seeded=CheckFirst; paceCtr=0.
- Pop definition: a pop occurs at a posedge rclk where r=1 and rempty=0. The word consumed is the rd value at that edge. No other edge consumes data.
- States:
  - IDLE: r=0. Goes to READ next cycle if en=1.
  - READ: r=en.
    - en=0 -> IDLE.
    - Pop with pace==0 -> stay in READ; back-to-back pops, one per cycle.
    - Pop with pace!=0 -> paceCtr<=pace, go to WAIT.
    - rempty=1 -> stay in READ, no pop, no counter change.
  - WAIT: r=0.
    - en=0 -> IDLE; paceCtr is discarded.
    - Otherwise paceCtr<=paceCtr-1; when paceCtr==1, go to READ. This gives exactly `pace` cycles with r=0 between pops.
  - ERR: r=0 permanently. Only reset exits ERR.
- Check on each pop:
  - If seeded=0: expected<=rd+1, seeded<=1; no compare.
  - If seeded=1 and rd==expected: expected<=rd+1.
  - If seeded=1 and rd!=expected: errExpected<=expected, errGot<=rd, ok<=0, state<=ERR.
  - The erroring pop still counts (rcount increments), and its word is removed from the FIFO.
- Arithmetic:
  - expected wraps modulo 2^Width; 0xFFF followed by 0x000 (Width=12) is valid.
  - rcount saturates and never wraps.
- Sequence state across IDLE: expected and seeded persist while en toggles, so pausing never causes a false error.
- en dropping during a cycle with rempty=0: r drops combinationally, so no pop occurs at that edge.
- Reset mid-operation:
  - All state returns to reset values immediately.
  - r drops to 0 asynchronously.
  - The FIFO's contents are not this block's concern; after reset with CheckFirst=0 the next word reseeds.
- Outputs ok/rcount/errExpected/errGot are registered; they are valid on the cycle after the pop edge.

Test Plan:
- Seeded stream: CheckFirst=0, pace=0, en=1; FIFO fed 5,6,7,8 -> 4 pops on consecutive non-empty cycles, rcount=4, ok=1.
- Wrap: Width=12, FIFO fed 0xFFE,0xFFF,0x000,0x001 -> ok=1, rcount=4.
- Mismatch: FIFO fed 0,1,2,4,5 with CheckFirst=1 -> ok falls after the 4th pop; errExpected=3, errGot=4; rcount=4; r stays 0 afterwards; the word 5 remains unpopped.
- CheckFirst: CheckFirst=1, first word 7 -> ok=0, errExpected=0, errGot=7, rcount=1.
- Pacing/full: slow wclk producer (period 84 vs rclk 6), fast producer variant, pace=15 -> exactly 15 r=0 cycles between pops; FIFO reaches wfull; after pace=0 the sequence resumes with ok=1.
- Pause/reset: toggle en every 3 cycles during streaming -> no false error, rcount equals the number of words written. Then assert rrst_ mid-READ -> r drops immediately, ok=1, rcount=0, next word reseeds.
